// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word-aligned fetches under a credit limit,
// buffers in-order responses in a small FIFO toward decode, and squashes stale responses on redirect.
module fetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h8000_0000),
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = CNT_W + INF_W + 1;

  localparam logic [INF_W-1:0] MAX_INF    = INF_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0] DEPTH_S    = SUM_W'(DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [INF_W-1:0] inflight;
  logic [INF_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic             req_fire;
  logic             resp_fire;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] committed;

  // Credit check: buffered entries plus responses that will be kept must leave room.
  always_comb begin
    committed      = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(drop_cnt);
    imem_req_valid = !rst && !redirect_valid && (inflight < MAX_INF) && (committed < DEPTH_S);
    instr_valid    = !rst && !redirect_valid && (count != '0);
    req_fire       = imem_req_valid && imem_req_ready;
    resp_fire      = imem_resp_valid && (inflight != '0);
    push           = resp_fire && (drop_cnt == '0) && !redirect_valid;
    pop            = instr_valid && instr_ready;
  end

  assign imem_req_addr = fetch_pc;
  assign instr         = instr_mem[rd_ptr];
  assign instr_pc      = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight + INF_W'(req_fire) - INF_W'(resp_fire);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path, except a response landing now.
        fetch_pc <= redirect_pc & ALIGN_MASK;
        resp_pc  <= redirect_pc & ALIGN_MASK;
        drop_cnt <= inflight - INF_W'(resp_fire);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - INF_W'(1);
        if (push) begin
          resp_pc <= resp_pc + PC_STEP;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Buffer storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h80000000, first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, instruction buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, max unanswered memory requests (1..DEPTH).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-008 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-009 SHALL have port imem_req_addr  out  XLEN  fetch address, word aligned.
REQ-010 SHALL have port imem_resp_valid  in  1  in-order response strobe.
REQ-011 SHALL have port imem_resp_data  in  32  fetched instruction.
REQ-012 SHALL have port redirect_valid  in  1  branch/jump/trap redirect, flushes the front end.
REQ-013 SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-014 SHALL have port instr_valid  out  1  buffer head valid toward decode.
REQ-015 SHALL have port instr_ready  in  1  decode accepts head (deasserted on stall).
REQ-016 SHALL have port instr  out  32  head instruction.
REQ-017 SHALL have port instr_pc  out  XLEN  PC of head instruction.

Function
REQ-018 SHALL hold fetch_pc (next request address), resp_pc (PC of next kept response), inflight (0..MAX_OUTSTANDING), drop_cnt (0..inflight), and a DEPTH-entry FIFO of {pc, instr} with count 0..DEPTH.
REQ-019 SHALL drive imem_req_valid = !redirect_valid && inflight < MAX_OUTSTANDING && count + (inflight - drop_cnt) < DEPTH; imem_req_addr = fetch_pc.
REQ-020 SHALL, on request handshake (valid && ready), increment fetch_pc by 4 modulo 2^XLEN and increment inflight.
REQ-021 SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-022 SHALL decrement inflight on each imem_resp_valid; simultaneous request handshake and response leave inflight unchanged.
REQ-023 SHALL discard a response while drop_cnt>0 and decrement drop_cnt; otherwise push {resp_pc, imem_resp_data} and increment resp_pc by 4 (wrap).
REQ-024 SHALL guarantee by the credit rule of REQ-019 that a kept response never meets a full FIFO.
REQ-025 SHALL ignore imem_resp_valid when inflight=0 (no counter underflow, no push).
REQ-026 SHALL drive instr_valid = (count!=0) && !redirect_valid; instr/instr_pc = FIFO head, combinational from storage.
REQ-027 SHALL pop the head on instr_valid && instr_ready; push and pop in the same cycle leave count unchanged; push to an empty FIFO appears on instr_valid next cycle (1-cycle response-to-decode latency).
REQ-028 SHALL, on redirect_valid, in that cycle: empty the FIFO, set fetch_pc and resp_pc to {redirect_pc[XLEN-1:2], 2'b00}, set drop_cnt to inflight minus 1 if imem_resp_valid that cycle else inflight, ignore instr_ready, issue no request.
REQ-029 SHALL let redirect override any simultaneous push, pop, or drop of the same cycle.
REQ-030 SHALL resume requests in the cycle after redirect, subject to REQ-019.
REQ-031 SHALL accept back-to-back redirects; each one recomputes drop_cnt per REQ-028.

Reset
REQ-032 SHALL, while rst=1, immediately force fetch_pc=resp_pc=RESET_PC, inflight=0, drop_cnt=0, count=0, imem_req_valid=0, instr_valid=0.
REQ-033 SHALL drive imem_req_valid=1 with addr RESET_PC in the first cycle after rst deasserts, provided redirect_valid=0.
REQ-034 SHALL, on reset asserted mid-operation, abandon outstanding requests; the environment resets memory alongside.

Verification
REQ-035 SHALL test reset release with ready=1, 1-cycle memory, instr_ready=1 -> requests 0x80000000, 0x80000004 consecutive; instr_pc 0x80000000 appears 2 cycles after first request.
REQ-036 SHALL test instr_ready=0 with DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests issued, then imem_req_valid=0; count=4, no overflow.
REQ-037 SHALL test redirect to 0x80000102 with 2 requests in flight -> next request addr 0x80000100; both stale responses dropped; first instr_pc 0x80000100.
REQ-038 SHALL test redirect in the same cycle as a response and a pop -> FIFO empty, drop_cnt = inflight-1, instr_valid=0 that cycle.
REQ-039 SHALL test imem_req_ready=0 for 5 cycles -> addr held constant; fetch_pc advances only on handshake.
REQ-040 SHALL test fetch_pc=0xFFFFFFFC -> next request addr 0x00000000.
